// File: rtl/dest_pipe_hazard_unit_pkg.sv
// Shared constants for the destination-register pipeline and the operand forwarding logic.
package dest_pipe_hazard_unit_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/dest_pipe_hazard_unit_fwd_compare.sv
// Operand forwarding select for one EX source register; MEM has priority over WB.
module dest_pipe_hazard_unit_fwd_compare
  import dest_pipe_hazard_unit_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] mem_dst,
  input  logic       mem_we,
  input  logic [4:0] wb_dst,
  input  logic       wb_we,
  output logic [1:0] sel
);

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hardwired, so a write to it never counts as a producer.
  assign mem_hit = mem_we && (mem_dst != REG_ZERO) && (mem_dst == src);
  assign wb_hit  = wb_we  && (wb_dst  != REG_ZERO) && (wb_dst  == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/dest_pipe_hazard_unit.sv
// Tracks the EX destination register through MEM/WB, drives forwarding selects,
// the load-use stall, the register file write port and a saturating stall counter.
module dest_pipe_hazard_unit
  import dest_pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             hold,
  input  logic [4:0]       ex_dst,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic [4:0]       wb_dst,
  output logic             wb_regwrite,
  output logic [CNT_W-1:0] stall_count
);

  logic [4:0] mem_dst;
  logic       mem_regwrite;
  logic       ex_load_writes;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_dst      <= REG_ZERO;
      mem_regwrite <= 1'b0;
      wb_dst       <= REG_ZERO;
      wb_regwrite  <= 1'b0;
    end else if (!hold) begin
      mem_dst      <= ex_dst;
      mem_regwrite <= ex_regwrite;
      wb_dst       <= mem_dst;
      wb_regwrite  <= mem_regwrite;
    end
  end

  // Bubble insertion is the ID/EX register's job; EX capture is not gated by stall.
  assign ex_load_writes = ex_memread && ex_regwrite && (ex_dst != REG_ZERO);
  assign stall = ex_load_writes &&
                 ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_count <= '0;
    end else if (!hold && stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  dest_pipe_hazard_unit_fwd_compare u_fwd_a (
    .src     (ex_rs),
    .mem_dst (mem_dst),
    .mem_we  (mem_regwrite),
    .wb_dst  (wb_dst),
    .wb_we   (wb_regwrite),
    .sel     (fwd_a)
  );

  dest_pipe_hazard_unit_fwd_compare u_fwd_b (
    .src     (ex_rt),
    .mem_dst (mem_dst),
    .mem_we  (mem_regwrite),
    .wb_dst  (wb_dst),
    .wb_we   (wb_regwrite),
    .sel     (fwd_b)
  );

endmodule
